// File: rtl/gate_exerciser_if.sv
// gate_exerciser_if
//   Groups the exerciser's control, stimulus and result signals.
//   master : board/tester side. It drives start and the gate unit results, and
//            observes stimulus and status.
//   slave  : the gate_exerciser itself.
//   Signals:
//     start                      begin a test run
//     a_out, b_out               stimulus to the gate unit
//     and_in .. nand_in          gate unit results
//     busy, done, pass           run status
//     err_count[3:0]             mismatching vector count, saturating
//     fail_vec[5:0]              sticky per-gate fail flags {nand,xnor,xor,not_a,or,and}
//     vec_idx[1:0]               vector currently driven
//   Optional macro GATE_EXER_FIRST_FAIL_EN adds first_fail_valid and
//   first_fail_idx[1:0].
interface gate_exerciser_if;
  logic       start;
  logic       a_out;
  logic       b_out;
  logic       and_in;
  logic       or_in;
  logic       not_a_in;
  logic       xor_in;
  logic       xnor_in;
  logic       nand_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [5:0] fail_vec;
  logic [1:0] vec_idx;
`ifdef GATE_EXER_FIRST_FAIL_EN
  logic       first_fail_valid;
  logic [1:0] first_fail_idx;

  modport master (
    output start, and_in, or_in, not_a_in, xor_in, xnor_in, nand_in,
    input  a_out, b_out, busy, done, pass, err_count, fail_vec, vec_idx,
           first_fail_valid, first_fail_idx
  );

  modport slave (
    input  start, and_in, or_in, not_a_in, xor_in, xnor_in, nand_in,
    output a_out, b_out, busy, done, pass, err_count, fail_vec, vec_idx,
           first_fail_valid, first_fail_idx
  );
`else
  modport master (
    output start, and_in, or_in, not_a_in, xor_in, xnor_in, nand_in,
    input  a_out, b_out, busy, done, pass, err_count, fail_vec, vec_idx
  );

  modport slave (
    input  start, and_in, or_in, not_a_in, xor_in, xnor_in, nand_in,
    output a_out, b_out, busy, done, pass, err_count, fail_vec, vec_idx
  );
`endif
endinterface

// File: rtl/gate_exerciser.sv
// gate_exerciser
//   Built-in self-test engine for a two-input gate unit. It sweeps the four
//   (a,b) vectors 00,01,10,11 and holds each one for SETTLE_CYCLES cycles. A
//   single CHECK cycle then compares the six gate results against internally
//   computed golden values. The sweep repeats PASSES times per start.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  gate_exerciser_if.slave (start, stimulus, results, status)
//   Parameters:
//     SETTLE_CYCLES  cycles each vector is held before checking (1..15)
//     PASSES         full 4-vector sweeps per start (1..15)
//   Optional macro GATE_EXER_FIRST_FAIL_EN records the vector index of the
//   first failing CHECK of a run (first_fail_valid / first_fail_idx).
module gate_exerciser #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned PASSES        = 1
) (
  input  logic             clk,
  input  logic             rst,
  gate_exerciser_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] PASS_LAST   = 4'(PASSES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] settle_cnt;
  logic [3:0] pass_cnt;
  logic [1:0] vec_idx;
  logic [3:0] err_count;
  logic [5:0] fail_vec;
  logic [5:0] actual;
  logic [5:0] mismatch;
  logic       settle_end;
  logic       last_vec;

`ifdef GATE_EXER_FIRST_FAIL_EN
  logic       first_fail_valid;
  logic [1:0] first_fail_idx;
`endif

  // Golden results for vector v = {a,b}, packed as {nand,xnor,xor,not_a,or,and}.
  function automatic logic [5:0] golden_of(input logic [1:0] v);
    logic a;
    logic b;
    a = v[1];
    b = v[0];
    return {~(a & b), ~(a ^ b), a ^ b, ~a, a | b, a & b};
  endfunction

  // Mismatch counter increment that sticks at 15.
  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'hF) ? 4'hF : c + 4'd1;
  endfunction

  assign actual     = {bus.nand_in, bus.xnor_in, bus.xor_in,
                       bus.not_a_in, bus.or_in, bus.and_in};
  assign mismatch   = actual ^ golden_of(vec_idx);
  assign settle_end = (settle_cnt == SETTLE_LAST);
  assign last_vec   = (vec_idx == 2'd3) && (pass_cnt == PASS_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. start only matters in IDLE and DONE, so a start while
  // busy is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.start) state_nxt = SETTLE;
      SETTLE:     if (settle_end) state_nxt = CHECK;
      CHECK:      state_nxt = last_vec ? DONE : SETTLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Outputs. The stimulus comes straight from the vector index, so it stays
  // on the last vector while DONE.
  always_comb begin
    bus.busy      = (state == SETTLE) || (state == CHECK);
    bus.done      = (state == DONE);
    bus.pass      = (state == DONE) && (err_count == 4'd0);
    bus.a_out     = vec_idx[1];
    bus.b_out     = vec_idx[0];
    bus.vec_idx   = vec_idx;
    bus.err_count = err_count;
    bus.fail_vec  = fail_vec;
`ifdef GATE_EXER_FIRST_FAIL_EN
    bus.first_fail_valid = first_fail_valid;
    bus.first_fail_idx   = first_fail_idx;
`endif
  end

  // Sweep counters and result accumulation. Results are used only in CHECK.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= 4'd0;
      pass_cnt   <= 4'd0;
      vec_idx    <= 2'd0;
      err_count  <= 4'd0;
      fail_vec   <= 6'd0;
`ifdef GATE_EXER_FIRST_FAIL_EN
      first_fail_valid <= 1'b0;
      first_fail_idx   <= 2'd0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            settle_cnt <= 4'd0;
            pass_cnt   <= 4'd0;
            vec_idx    <= 2'd0;
            err_count  <= 4'd0;
            fail_vec   <= 6'd0;
`ifdef GATE_EXER_FIRST_FAIL_EN
            first_fail_valid <= 1'b0;
            first_fail_idx   <= 2'd0;
`endif
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 4'd1;
        end
        CHECK: begin
          fail_vec <= fail_vec | mismatch;
          if (|mismatch) begin
            err_count <= sat_inc(err_count);
`ifdef GATE_EXER_FIRST_FAIL_EN
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_idx   <= vec_idx;
            end
`endif
          end
          if (!last_vec) begin
            vec_idx    <= vec_idx + 2'd1;
            settle_cnt <= 4'd0;
            if (vec_idx == 2'd3) pass_cnt <= pass_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_exerciser.sv
module tb_gate_exerciser;

  localparam int S  = 2;
  localparam int P1 = 5;

  typedef struct {
    int         lat;
    logic [3:0] err;
    logic [5:0] fail;
    logic       pass;
    logic       ffv;
    logic [1:0] ffi;
  } exp_t;

  logic clk;
  logic rst;
  int   mode;
  int   sel;
  int   n_total;
  int   n_bad;
  exp_t sb[$];

  gate_exerciser_if i0 ();
  gate_exerciser_if i1 ();

  gate_exerciser #(.SETTLE_CYCLES(S), .PASSES(1)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (i0.slave)
  );

  gate_exerciser #(.SETTLE_CYCLES(S), .PASSES(P1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (i1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate unit model with selectable faults; packed {nand,xnor,xor,not_a,or,and}.
  function automatic logic [5:0] gate_model(input int m, input logic a, input logic b);
    logic [5:0] r;
    r = {~(a & b), ~(a ^ b), a ^ b, ~a, a | b, a & b};
    case (m)
      1: r[0] = 1'b0;
      2: r[4] = a ^ b;
      3: r = ~r;
      default: ;
    endcase
    return r;
  endfunction

  // Reference truth table written per vector index.
  function automatic logic [5:0] golden(input int v);
    logic [5:0] g;
    g[0] = (v == 3);
    g[1] = (v != 0);
    g[2] = (v < 2);
    g[3] = (v == 1) || (v == 2);
    g[4] = (v == 0) || (v == 3);
    g[5] = (v != 3);
    return g;
  endfunction

  function automatic exp_t predict(input int np);
    exp_t       e;
    logic [5:0] mm;
    e.lat  = np * 4 * (S + 1);
    e.err  = 4'd0;
    e.fail = 6'd0;
    e.ffv  = 1'b0;
    e.ffi  = 2'd0;
    for (int p = 0; p < np; p++) begin
      for (int v = 0; v < 4; v++) begin
        mm = golden(v) ^ gate_model(mode, v[1], v[0]);
        e.fail = e.fail | mm;
        if (mm != 6'd0) begin
          if (e.err != 4'hF) e.err = e.err + 4'd1;
          if (!e.ffv) begin
            e.ffv = 1'b1;
            e.ffi = v[1:0];
          end
        end
      end
    end
    e.pass = (e.err == 4'd0);
    return e;
  endfunction

  always_comb begin
    {i0.nand_in, i0.xnor_in, i0.xor_in, i0.not_a_in, i0.or_in, i0.and_in} =
      gate_model(mode, i0.a_out, i0.b_out);
    {i1.nand_in, i1.xnor_in, i1.xor_in, i1.not_a_in, i1.or_in, i1.and_in} =
      gate_model(mode, i1.a_out, i1.b_out);
  end

  logic       s_done, s_busy, s_pass, s_a, s_b, s_ffv;
  logic [3:0] s_err;
  logic [5:0] s_fail;
  logic [1:0] s_vec, s_ffi;

  always_comb begin
    s_ffv = 1'b0;
    s_ffi = 2'd0;
    if (sel == 0) begin
      s_done = i0.done; s_busy = i0.busy; s_pass = i0.pass;
      s_a = i0.a_out; s_b = i0.b_out; s_err = i0.err_count;
      s_fail = i0.fail_vec; s_vec = i0.vec_idx;
`ifdef GATE_EXER_FIRST_FAIL_EN
      s_ffv = i0.first_fail_valid; s_ffi = i0.first_fail_idx;
`endif
    end else begin
      s_done = i1.done; s_busy = i1.busy; s_pass = i1.pass;
      s_a = i1.a_out; s_b = i1.b_out; s_err = i1.err_count;
      s_fail = i1.fail_vec; s_vec = i1.vec_idx;
`ifdef GATE_EXER_FIRST_FAIL_EN
      s_ffv = i1.first_fail_valid; s_ffi = i1.first_fail_idx;
`endif
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Starts a run on instance inst and follows it to done.
  // inject: 0 none, 1 reset during vec 2 settle, 2 start pulse while busy at vec 1.
  task automatic run_one(input int inst, input int np, input int inject);
    exp_t e;
    int   cyc;
    int   bound;
    bit   seen;
    sel = inst;
    sb.push_back(predict(np));
    if (inst == 0) i0.start = 1'b1; else i1.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i0.start = 1'b0;
    i1.start = 1'b0;
    cyc   = 0;
    seen  = 0;
    bound = np * 4 * (S + 1) + 20;
    check("start_clr_done", {31'd0, s_done}, 32'd0);
    check("start_clr_pass", {31'd0, s_pass}, 32'd0);
    while (!seen && cyc <= bound) begin
      if (s_done) begin
        seen = 1;
        if (sb.size() == 0) begin
          check("sb_empty", 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          check("latency", cyc, e.lat);
          check("err_count", {28'd0, s_err}, {28'd0, e.err});
          check("fail_vec", {26'd0, s_fail}, {26'd0, e.fail});
          check("pass", {31'd0, s_pass}, {31'd0, e.pass});
          check("busy_done", {31'd0, s_busy}, 32'd0);
          check("ab_last", {30'd0, s_a, s_b}, 32'd3);
`ifdef GATE_EXER_FIRST_FAIL_EN
          check("ff_valid", {31'd0, s_ffv}, {31'd0, e.ffv});
          check("ff_idx", {30'd0, s_ffi}, {30'd0, e.ffi});
`endif
        end
      end else begin
        check("busy_run", {31'd0, s_busy}, 32'd1);
        if (inst == 0 && cyc < 4 * (S + 1)) begin
          check("vec_idx", {30'd0, s_vec}, (cyc / (S + 1)) % 4);
          check("ab_seq", {30'd0, s_a, s_b}, (cyc / (S + 1)) % 4);
        end
        if (inject == 1 && cyc == 6) begin
          rst = 1'b1;
          @(negedge clk);
          check("rst_state_busy", {31'd0, s_busy}, 32'd0);
          check("rst_state_ab", {30'd0, s_a, s_b}, 32'd0);
          check("rst_state_err", {28'd0, s_err}, 32'd0);
          check("rst_state_vec", {30'd0, s_vec}, 32'd0);
          check("rst_state_done", {31'd0, s_done}, 32'd0);
          rst = 1'b0;
          sb.delete();
          return;
        end
        if (inject == 2) begin
          if (cyc == 3) i0.start = 1'b1;
          if (cyc == 4) i0.start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    n_total  = 0;
    n_bad    = 0;
    rst      = 1'b1;
    mode     = 0;
    sel      = 0;
    i0.start = 1'b0;
    i1.start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, s_busy}, 32'd0);
    check("reset_done", {31'd0, s_done}, 32'd0);
    check("reset_pass", {31'd0, s_pass}, 32'd0);
    check("reset_err", {28'd0, s_err}, 32'd0);
    check("reset_fail", {26'd0, s_fail}, 32'd0);
    check("reset_ab", {30'd0, s_a, s_b}, 32'd0);
    check("reset_busy1", {31'd0, i1.busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    mode = 0; run_one(0, 1, 0);
    repeat (2) @(negedge clk);
    check("done_hold", {31'd0, s_done}, 32'd1);
    check("pass_hold", {31'd0, s_pass}, 32'd1);

    mode = 1; run_one(0, 1, 0);
    mode = 2; run_one(0, 1, 0);
    mode = 3; run_one(1, P1, 0);

    mode = 0; run_one(0, 1, 1);
    @(negedge clk);
    run_one(0, 1, 0);
    run_one(0, 1, 2);
    run_one(0, 1, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/gate_exerciser.md
Name: gate_exerciser

Overview:
Sequential stimulus-and-check engine for the two-input gate unit. It sits on the other side of that unit's interface: it drives a and b and checks the and/or/not_a/xor/xnor/nand results. It sweeps all four input vectors, waits a settle interval, and compares each result against golden values computed internally. It reports per-gate sticky failure flags, a mismatch count, and pass/done status. It is used for built-in self-test of gate units on the board.

Parameters:
SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..15
PASSES, 1, number of full 4-vector sweeps per start; legal range 1..15

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-high
start  input  1  begin a test run; sampled only in IDLE or DONE
a_out  output  1  stimulus to the gate unit's a input
b_out  output  1  stimulus to the gate unit's b input
and_in  input  1  gate unit and result
or_in  input  1  gate unit or result
not_a_in  input  1  gate unit not-a result
xor_in  input  1  gate unit xor result
xnor_in  input  1  gate unit xnor result
nand_in  input  1  gate unit nand result
busy  output  1  high while in SETTLE or CHECK
done  output  1  high in DONE; held until the next start or reset
pass  output  1  valid when done=1; high iff err_count==0
err_count  output  4  number of checked vectors with any mismatch; saturates at 15
fail_vec  output  6  sticky per-gate fail flags {nand,xnor,xor,not_a,or,and}; bit0=and
vec_idx  output  2  index of the vector currently driven

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset (any state, including mid-run): state=IDLE; a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, vec_idx=0. Internal counters are cleared.
- Vector mapping: a_out=vec_idx[1], b_out=vec_idx[0]. Sweep order is 0,1,2,3, i.e. (a,b) = 00, 01, 10, 11.
- Golden values: and=a&b, or=a|b, not_a=~a, xor=a^b, xnor=~(a^b), nand=~(a&b).
- States:
  - IDLE: start=1 -> clear err_count, fail_vec, done and pass; set vec_idx=0, settle counter=0, pass counter=0; go to SETTLE.
  - SETTLE: increment the settle counter each cycle; when the counter reaches SETTLE_CYCLES-1, go to CHECK. Stimulus is held stable throughout.
  - CHECK (one cycle): compute mismatch = actual XOR golden (6 bits); fail_vec |= mismatch; if mismatch != 0, err_count = min(err_count+1, 15).
    - If vec_idx==3 and pass counter == PASSES-1 -> go to DONE.
    - Otherwise advance: vec_idx+1 (wrapping 3->0 and incrementing the pass counter on wrap), clear the settle counter, go to SETTLE.
  - DONE: done=1, pass=(err_count==0); a_out/b_out stay at the last vector. start=1 -> same actions as start in IDLE.
- Latency: done rises exactly PASSES*4*(SETTLE_CYCLES+1) cycles after the edge that samples start. With defaults this is 12 cycles.
- start while busy=1: ignored, no restart.
- rst and start asserted together: rst wins.
- Results are sampled only in CHECK; input glitches during SETTLE have no effect.

Optional Feature:
GATE_EXER_FIRST_FAIL_EN
- Defined: adds outputs first_fail_valid (1 bit) and first_fail_idx (2 bits). On the first CHECK cycle of a run with nonzero mismatch, these capture vec_idx and set valid=1. They hold until the next start or reset, which clears both to 0. Later failures do not overwrite them.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
1. Correct gate model, defaults, pulse start -> busy=1 for 12 cycles; then done=1, pass=1, err_count=0, fail_vec=6'h00; a_out,b_out sequence is 00,01,10,11, each held 3 cycles.
2. and_in stuck at 0 -> err_count=1, fail_vec=6'h01, pass=0; with the macro defined, first_fail_idx=3 and first_fail_valid=1.
3. xnor_in driven from the xor function -> mismatch on all four vectors: err_count=4, fail_vec=6'h10, first_fail_idx=0.
4. PASSES=5, all six results inverted -> 20 mismatching vectors; err_count saturates at 15, fail_vec=6'h3F, done after 60 cycles.
5. Assert rst during SETTLE of vec_idx=2 -> next cycle state is IDLE, a_out=b_out=0, busy=0, err_count=0. A later start runs a full clean sweep.
6. Pulse start again while busy=1 at vec_idx=1 -> ignored; done still rises at cycle 12 of the original run. A start while done=1 clears done and pass and restarts from vec_idx=0.
